neuromorphic_xn_macro: RTL and testbench

Parametrised, in-order behavioural/RTL model of a ReRAM neuromorphic array macro, generalised in rows, columns, cell width and command depth. It sits behind the Wishbone slave. A bounded command queue feeds a single execution engine that models independent programmable read and write latencies. Array contents are non-volatile: reset flushes pending commands but never clears the array.

---
 rtl/neuromorphic_xn_pkg.sv | 24 ++
 rtl/neuromorphic_xn_cmd_fifo.sv | 50 +++++
 rtl/neuromorphic_xn_macro.sv | 139 +++++++++++++
 tb/tb_neuromorphic_xn_macro.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/neuromorphic_xn_pkg.sv
// rtl/neuromorphic_xn_pkg.sv - shared types and field-width helpers for the ReRAM array macro
package neuromorphic_xn_pkg;

  // Row/col fields are sized for the largest supported array (256x256).
  typedef struct packed {
    logic        rd;
    logic        bad;
    logic [7:0]  row;
    logic [7:0]  col;
    logic [31:0] data;
    logic [3:0]  sel;
  } cmd_t;

  typedef enum logic {IDLE, EXEC} eng_state_t;

  // Bits needed to index n entries, never less than one.
  function automatic int fld_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/neuromorphic_xn_cmd_fifo.sv
// rtl/neuromorphic_xn_cmd_fifo.sv - command queue with asynchronous flush
module neuromorphic_xn_cmd_fifo
  import neuromorphic_xn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLKin,
  input  logic                     RSTin,
  input  logic                     i_push,
  input  cmd_t                     i_din,
  input  logic                     i_pop,
  output cmd_t                     o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [fld_w(DEPTH):0]    o_level
);

  localparam int PW = fld_w(DEPTH);

  cmd_t          r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_level;

  assign o_dout  = r_mem[r_rptr];
  assign o_full  = (r_level == (PW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

  always_ff @(posedge CLKin or negedge RSTin) begin
    if (!RSTin) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge CLKin) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/neuromorphic_xn_macro.sv
// rtl/neuromorphic_xn_macro.sv - in-order ReRAM array macro with queued commands and modelled latency
module neuromorphic_xn_macro
  import neuromorphic_xn_pkg::*;
#(
  parameter int ROWS      = 32,
  parameter int COLS      = 32,
  parameter int DW        = 8,
  parameter int CMD_DEPTH = 4,
  parameter int RD_DLY    = 44,
  parameter int WR_DLY    = 10
) (
  input  logic                         CLKin,
  input  logic                         RSTin,
  input  logic                         EN,
  input  logic                         R_WB,
  input  logic [31:0]                  AD,
  input  logic [31:0]                  DI,
  input  logic [3:0]                   SEL,
  output logic                         req_rdy,
  output logic [31:0]                  DO,
  output logic                         func_ack,
  output logic                         err,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   level
);

  localparam int RB    = fld_w(ROWS);
  localparam int CB    = fld_w(COLS);
  localparam int AW    = RB + CB;
  localparam int NB    = DW / 8;
  localparam int MAXD  = (RD_DLY > WR_DLY) ? RD_DLY : WR_DLY;
  localparam int CNT_W = fld_w(MAXD);

  cmd_t             w_in;
  cmd_t             w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_done;
  logic [AW-1:0]    w_idx;
  logic             w_unused;
  eng_state_t       r_state;
  eng_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  cmd_t             r_cmd;
  logic             r_live;
  logic             r_ack;
  logic             r_err;
  logic [31:0]      r_do;
  logic [DW-1:0]    r_mem [ROWS*COLS];

  assign w_in = '{rd:   R_WB,
                  bad:  |AD[31:AW],
                  row:  8'(AD[AW-1:CB]),
                  col:  8'(AD[CB-1:0]),
                  data: DI,
                  sel:  SEL};

  // r_live keeps req_rdy low until the first edge after reset release.
  assign req_rdy  = r_live && !w_full;
  assign w_push   = EN && req_rdy;
  assign w_done   = (r_state == EXEC) && (r_cnt == '0);
  assign w_idx    = {r_cmd.row[RB-1:0], r_cmd.col[CB-1:0]};
  assign w_unused = ^r_cmd;
  assign DO       = r_do;
  assign func_ack = r_ack;
  assign err      = r_err;
  assign busy     = (r_state == EXEC) || !w_empty;

  neuromorphic_xn_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .CLKin   (CLKin),
    .RSTin   (RSTin),
    .i_push  (w_push),
    .i_din   (w_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = EXEC;
          w_cnt_nxt   = w_head.rd ? CNT_W'(RD_DLY - 1) : CNT_W'(WR_DLY - 1);
        end
      end
      EXEC: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (!w_empty) begin
          w_pop     = 1'b1;
          w_cnt_nxt = w_head.rd ? CNT_W'(RD_DLY - 1) : CNT_W'(WR_DLY - 1);
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLKin or negedge RSTin) begin
    if (!RSTin) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cmd   <= '0;
      r_live  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_do    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_live  <= 1'b1;
      r_ack   <= w_done;
      r_err   <= w_done && r_cmd.bad;
      if (w_pop) r_cmd <= w_head;
      if (w_done && r_cmd.rd && !r_cmd.bad) r_do <= 32'(r_mem[w_idx]);
    end
  end

  // Array is non-volatile: no reset on the cell storage.
  always_ff @(posedge CLKin) begin
    if (w_done && !r_cmd.rd && !r_cmd.bad) begin
      for (int i = 0; i < NB; i++) begin
        if (r_cmd.sel[i]) r_mem[w_idx][8*i +: 8] <= r_cmd.data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_neuromorphic_xn_macro.sv
// tb/tb_neuromorphic_xn_macro.sv - directed bench for the ReRAM array macro (DW=8 and DW=16 instances)
module tb_neuromorphic_xn_macro;

  logic        CLKin = 1'b0;
  logic        RSTin = 1'b0;
  logic        r_wb  = 1'b0;
  logic [31:0] ad    = '0;
  logic [31:0] di    = '0;
  logic [3:0]  sel   = '0;
  logic        en8   = 1'b0;
  logic        en16  = 1'b0;

  logic        rdy8, ack8, err8, busy8;
  logic [31:0] do8;
  logic [2:0]  lvl8;
  logic        rdy16, ack16, err16, busy16;
  logic [31:0] do16;
  logic [2:0]  lvl16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLKin = ~CLKin;

  neuromorphic_xn_macro #(.ROWS(32), .COLS(32), .DW(8), .CMD_DEPTH(4), .RD_DLY(4), .WR_DLY(3)) u_dut8 (
    .CLKin(CLKin), .RSTin(RSTin), .EN(en8), .R_WB(r_wb), .AD(ad), .DI(di), .SEL(sel),
    .req_rdy(rdy8), .DO(do8), .func_ack(ack8), .err(err8), .busy(busy8), .level(lvl8)
  );

  neuromorphic_xn_macro #(.ROWS(32), .COLS(32), .DW(16), .CMD_DEPTH(4), .RD_DLY(4), .WR_DLY(3)) u_dut16 (
    .CLKin(CLKin), .RSTin(RSTin), .EN(en16), .R_WB(r_wb), .AD(ad), .DI(di), .SEL(sel),
    .req_rdy(rdy16), .DO(do16), .func_ack(ack16), .err(err16), .busy(busy16), .level(lvl16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit d16, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    int k;
    k = 0;
    while (!(d16 ? rdy16 : rdy8) && k < 100) begin
      @(posedge CLKin); #1;
      k++;
    end
    check_eq("issue_rdy", d16 ? rdy16 : rdy8, 1);
    r_wb = rd; ad = a; di = d; sel = s;
    en8 = !d16; en16 = d16;
    @(posedge CLKin); #1;
    en8 = 1'b0; en16 = 1'b0;
  endtask

  task automatic wait_ack(input bit d16, input int lat, input logic exp_err, input string tag);
    int k;
    bit seen;
    k = 0; seen = 1'b0;
    while (!seen && k < 60) begin
      @(posedge CLKin); #1;
      k++;
      seen = d16 ? ack16 : ack8;
    end
    check_eq({tag, "_lat"}, k, lat);
    check_eq({tag, "_err"}, d16 ? err16 : err8, exp_err);
  endtask

  initial begin
    int acks[$];
    int exp_fill[5];
    bit any_ack;
    exp_fill = '{5, 8, 11, 14, 17};

    // Reset state
    #12;
    check_eq("rst_rdy", rdy8, 0);
    check_eq("rst_do", do8, 0);
    check_eq("rst_ack", ack8, 0);
    check_eq("rst_err", err8, 0);
    check_eq("rst_busy", busy8, 0);
    check_eq("rst_level", lvl8, 0);
    @(negedge CLKin); RSTin = 1'b1;
    @(posedge CLKin); #1;
    check_eq("rel_rdy", rdy8, 1);

    // Single write then read of row1 col5
    issue(0, 0, 32'h0000_0025, 32'h0000_00A5, 4'b0001);
    wait_ack(0, 4, 0, "wr1");
    @(posedge CLKin); #1;
    check_eq("ack_pulse", ack8, 0);
    issue(0, 1, 32'h0000_0025, 32'h0, 4'b0000);
    wait_ack(0, 5, 0, "rd1");
    check_eq("rd1_do", do8, 32'h0000_00A5);

    // Read occupies the engine, four writes fill the queue, fifth EN is refused
    acks.delete();
    for (int e = 0; e < 25; e++) begin
      if (e == 0) begin
        r_wb = 1; ad = 32'h25; en8 = 1;
      end else if (e <= 4) begin
        r_wb = 0; ad = 32'h100 + 32'(e - 1); di = 32'h10 + 32'(e - 1); sel = 4'b0001; en8 = 1;
      end else if (e == 5) begin
        check_eq("full_rdy", rdy8, 0);
        check_eq("full_level", lvl8, 4);
        r_wb = 0; ad = 32'h100; di = 32'hEE; sel = 4'b0001; en8 = 1;
      end else begin
        en8 = 0;
      end
      @(posedge CLKin); #1;
      if (ack8) acks.push_back(e);
    end
    en8 = 0;
    check_eq("fill_nacks", acks.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < acks.size()) check_eq("fill_ack_edge", acks[i], exp_fill[i]);
    end
    issue(0, 1, 32'h100, 32'h0, 4'b0000);
    wait_ack(0, 5, 0, "fill_rd0");
    check_eq("fill_ignored", do8, 32'h10);
    issue(0, 1, 32'h103, 32'h0, 4'b0000);
    wait_ack(0, 5, 0, "fill_rd3");
    check_eq("fill_last", do8, 32'h13);

    // Write then read queued back-to-back
    acks.delete();
    for (int e = 0; e < 12; e++) begin
      if (e == 0) begin
        r_wb = 0; ad = 32'h66; di = 32'h3C; sel = 4'b0001; en8 = 1;
      end else if (e == 1) begin
        r_wb = 1; ad = 32'h66; en8 = 1;
      end else begin
        en8 = 0;
      end
      @(posedge CLKin); #1;
      if (ack8) acks.push_back(e);
    end
    check_eq("b2b_nacks", acks.size(), 2);
    if (acks.size() == 2) begin
      check_eq("b2b_wr_edge", acks[0], 4);
      check_eq("b2b_rd_edge", acks[1], 8);
    end
    check_eq("b2b_do", do8, 32'h3C);

    // DW=16 byte enables
    issue(1, 0, 32'h0, 32'h0000_BEEF, 4'b0011);
    wait_ack(1, 4, 0, "w16a");
    issue(1, 0, 32'h0, 32'h0000_1234, 4'b0001);
    wait_ack(1, 4, 0, "w16b");
    issue(1, 1, 32'h0, 32'h0, 4'b0000);
    wait_ack(1, 5, 0, "r16");
    check_eq("dw16_do", do16, 32'h0000_BE34);

    // Out-of-range commands
    issue(0, 0, 32'h0, 32'h5A, 4'b0001);
    wait_ack(0, 4, 0, "c0_wr");
    issue(0, 1, 32'h0, 32'h0, 4'b0000);
    wait_ack(0, 5, 0, "c0_rd");
    check_eq("c0_do", do8, 32'h5A);
    issue(0, 0, 32'h0001_0000, 32'h99, 4'b0001);
    wait_ack(0, 4, 1, "bad_wr");
    check_eq("bad_wr_do", do8, 32'h5A);
    issue(0, 1, 32'h8000_0025, 32'h0, 4'b0000);
    wait_ack(0, 5, 1, "bad_rd");
    check_eq("bad_rd_do", do8, 32'h5A);
    issue(0, 1, 32'h0, 32'h0, 4'b0000);
    wait_ack(0, 5, 0, "c0_rd2");
    check_eq("c0_keep", do8, 32'h5A);

    // Reset mid-execution drops the in-flight write
    issue(0, 0, 32'h42, 32'h77, 4'b0001);
    wait_ack(0, 4, 0, "c22_wr");
    issue(0, 0, 32'h42, 32'h11, 4'b0001);
    @(posedge CLKin); #1;
    @(posedge CLKin); #3;
    RSTin = 1'b0;
    #1;
    check_eq("mid_busy", busy8, 0);
    check_eq("mid_level", lvl8, 0);
    check_eq("mid_do", do8, 0);
    check_eq("mid_rdy", rdy8, 0);
    any_ack = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge CLKin); #1;
      any_ack |= ack8;
    end
    @(negedge CLKin); RSTin = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(posedge CLKin); #1;
      any_ack |= ack8;
    end
    check_eq("mid_no_ack", any_ack, 0);
    issue(0, 1, 32'h42, 32'h0, 4'b0000);
    wait_ack(0, 5, 0, "c22_rd");
    check_eq("c22_keep", do8, 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
